ball_motion: RTL
================

# ball_motion

Parametrised ball controller for the brick-breaker playfield. It owns the ball position and direction registers and advances the ball by a programmable step on each `tick`. It bounces off the playfield walls by clamping and reflecting, and accepts external collision flips from the paddle and brick logic. It replaces the bare per-axis direction logic and sits between the game-control FSM (`start`, `tick`, `speed`) and the ball drawing path (`x`, `y`).

## Interface
Parameters:
- `COORD_W`, 10: coordinate width in bits.
- `SCREEN_W`, 320: playfield width in pixels.
- `SCREEN_H`, 240: playfield height in pixels.
- `SIZE`, 4: ball edge length. The legal range is x in [0, SCREEN_W-SIZE] and y in [0, SCREEN_H-SIZE].
- `STEP_W`, 3: width of the `speed` input.
- `START_X`, 158: launch x coordinate.
- `START_Y`, 200: launch y coordinate.

Ports:
- `clk` in 1: the single clock.
- `resetn` in 1: reset, asynchronous, active-low.
- `start` in 1: launch request. Honoured only in IDLE.
- `tick` in 1: one-cycle move strobe.
- `speed` in STEP_W: pixels moved per tick on each axis. A value of 0 means no motion.
- `hit_x` in 1: external collision. Reflects the x direction.
- `hit_y` in 1: external collision. Reflects the y direction.
- `x` out COORD_W: ball left edge.
- `y` out COORD_W: ball top edge.
- `x_dir` out 1: 1 = moving right (increasing x).
- `y_dir` out 1: 1 = moving down (increasing y).
- `moving` out 1: high in MOVE.
- `bounce` out 1: one-cycle pulse when a wall reflection occurs.
- `lost` out 1: one-cycle pulse when the ball exits at the bottom. Present only with the macro enabled; otherwise tied 0.

## Operation
- States:
  - IDLE: ball parked at START_X/START_Y.
  - MOVE: ball in play.
  - LOST: exists only with `BALL_LOST_EN`.
- Reset, or entry to IDLE, sets: x=START_X, y=START_Y, x_dir=1, y_dir=0, moving=0, bounce=0, lost=0.
- IDLE -> MOVE on the first edge where `start`=1. In MOVE, `start` is ignored.
- MOVE, per axis, evaluated each cycle:
  - Effective direction d' = dir XOR hit.
  - If `tick`=1, next = pos + speed when d'=1, else pos - speed.
  - Arithmetic is COORD_W+1 bits signed, so underflow below 0 is detected and never wraps.
- Clamping: if next < 0 or next > MAX (MAX = SCREEN_x - SIZE), then:
  - pos <= the violated bound;
  - dir <= away from that bound (1 at 0, 0 at MAX);
  - `bounce` asserts on the following cycle.
- Landing exactly on a bound also counts as a wall contact: reflect, with `bounce`.
- Without a tick, a hit updates dir only; the position holds.
- Wall reflection overrides an external hit on the same axis, so the direction always points away from the wall.
- A corner (both axes clamp in the same tick) produces a single `bounce` pulse.
- `hit_x` and `hit_y` are ignored outside MOVE.
- Bottom wall (y clamps to SCREEN_H-SIZE moving down) behaviour depends on the macro; see Configuration.

## Timing
- All outputs are registered. `x`, `y`, `x_dir`, `y_dir` update on the edge that samples `tick` or `hit_*`.
- `bounce` and `lost` are high for exactly one cycle, starting one edge after the clamping update.
- `moving` rises one edge after `start` is sampled.
- `tick` may be asserted on consecutive cycles. Each asserted cycle moves the ball once.
- A `resetn` low at any time, including mid-move or in LOST, forces the reset values immediately without waiting for a clock edge. Release is synchronised by the team's standard reset release.

## Configuration
- `BALL_LOST_EN` defined:
  - A bottom contact moves MOVE -> LOST, with y clamped to SCREEN_H-SIZE.
  - LOST lasts one cycle with `lost`=1, then goes to IDLE.
  - Entry to IDLE restores the start position and directions.
  - No `bounce` is generated for a bottom contact.
- `BALL_LOST_EN` undefined:
  - The LOST state is absent and `lost` is tied 0.
  - The bottom wall reflects like every other wall: y_dir <= 0, `bounce` pulses.

## Test plan
- Async reset: drive resetn=0 between clock edges -> x=158, y=200, x_dir=1, y_dir=0, moving=0, bounce=0 immediately.
- Launch and step: `start`, then speed=3 with one `tick` -> moving=1, x=161, y=197, no bounce.
- Right wall: x=314, x_dir=1, speed=3, tick -> x=316, x_dir=0, bounce high for one cycle. Top-left corner: x=1, y=1, both dirs 0, speed=3 -> x=0, y=0, both dirs 1, a single bounce pulse.
- External hit: y=100, y_dir=0, speed=2, `hit_y` together with `tick` -> y=102, y_dir=1, bounce=0. `hit_x` without tick -> x unchanged, x_dir toggled.
- Bottom, BALL_LOST_EN defined: y=234, y_dir=1, speed=3, tick -> y=236, lost high for one cycle, then IDLE with x=158, y=200, moving=0. Same stimulus with the macro undefined -> y=236, y_dir=0, bounce=1, lost=0.
- speed=0 with tick in MOVE -> x and y unchanged, no bounce. `start` during MOVE -> no effect.

Source files
------------

// File: rtl/ball_motion.sv
// Brick-breaker ball controller: position/direction registers, wall clamping and external hit flips.
// Optional macro BALL_LOST_EN turns the bottom wall into a loss (LOST state and `lost` pulse).
module ball_motion #(
  parameter int COORD_W  = 10,
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240,
  parameter int SIZE     = 4,
  parameter int STEP_W   = 3,
  parameter int START_X  = 158,
  parameter int START_Y  = 200
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic               tick,
  input  logic [STEP_W-1:0]  speed,
  input  logic               hit_x,
  input  logic               hit_y,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               x_dir,
  output logic               y_dir,
  output logic               moving,
  output logic               bounce,
  output logic               lost
);

  localparam int SW = COORD_W + 1;
  localparam logic signed [SW-1:0] MAX_X = SW'(SCREEN_W - SIZE);
  localparam logic signed [SW-1:0] MAX_Y = SW'(SCREEN_H - SIZE);
  localparam logic signed [SW-1:0] ZERO  = '0;
  localparam logic [1:0][COORD_W-1:0] START_POS = {COORD_W'(START_Y), COORD_W'(START_X)};
  localparam logic [1:0] START_DIR = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MOVE = 2'd1,
    S_LOST = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [1:0][COORD_W-1:0]   pos_q, pos_d;
  logic [1:0]                dir_q, dir_d;
  logic                      bounce_q, bounce_d;

  logic [1:0]                hit_v;
  logic [1:0]                lo_hit, hi_hit, ax_dir;
  logic [1:0][COORD_W-1:0]   ax_pos;
  logic                      active;

  assign hit_v  = {hit_y, hit_x};
  assign active = tick && (speed != '0);

  // Index 0 is the x axis, index 1 the y axis; both share the same move/clamp rule.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_axis
      localparam logic signed [SW-1:0] AX_MAX = (gi == 0) ? MAX_X : MAX_Y;
      logic signed [SW-1:0] cur, stp, nxt;
      logic                 d_eff;

      assign cur   = $signed({1'b0, pos_q[gi]});
      assign stp   = $signed(SW'(speed));
      assign d_eff = dir_q[gi] ^ hit_v[gi];
      assign nxt   = d_eff ? (cur + stp) : (cur - stp);

      assign lo_hit[gi] = active && (nxt <= ZERO);
      assign hi_hit[gi] = active && (nxt >= AX_MAX);

      assign ax_pos[gi] = !active    ? pos_q[gi] :
                          lo_hit[gi] ? '0 :
                          hi_hit[gi] ? AX_MAX[COORD_W-1:0] :
                                       nxt[COORD_W-1:0];
      assign ax_dir[gi] = lo_hit[gi] ? 1'b1 :
                          hi_hit[gi] ? 1'b0 : d_eff;
    end
  endgenerate

`ifdef BALL_LOST_EN
  logic lost_q, lost_d;
`endif

  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    dir_d    = dir_q;
    bounce_d = 1'b0;
`ifdef BALL_LOST_EN
    lost_d   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        pos_d = START_POS;
        dir_d = START_DIR;
        if (start) state_d = S_MOVE;
      end
      S_MOVE: begin
        pos_d    = ax_pos;
        dir_d    = ax_dir;
        bounce_d = (|lo_hit) | (|hi_hit);
`ifdef BALL_LOST_EN
        // A bottom contact is a loss, not a bounce; an x wall in the same tick still bounces.
        if (hi_hit[1]) begin
          state_d  = S_LOST;
          bounce_d = lo_hit[0] | hi_hit[0];
          lost_d   = 1'b1;
        end
`endif
      end
`ifdef BALL_LOST_EN
      S_LOST: begin
        state_d = S_IDLE;
        pos_d   = START_POS;
        dir_d   = START_DIR;
      end
`endif
      default: begin
        state_d = S_IDLE;
        pos_d   = START_POS;
        dir_d   = START_DIR;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      pos_q    <= START_POS;
      dir_q    <= START_DIR;
      bounce_q <= 1'b0;
`ifdef BALL_LOST_EN
      lost_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      dir_q    <= dir_d;
      bounce_q <= bounce_d;
`ifdef BALL_LOST_EN
      lost_q   <= lost_d;
`endif
    end
  end

  assign x      = pos_q[0];
  assign y      = pos_q[1];
  assign x_dir  = dir_q[0];
  assign y_dir  = dir_q[1];
  assign moving = (state_q == S_MOVE);
  assign bounce = bounce_q;
`ifdef BALL_LOST_EN
  assign lost   = lost_q;
`else
  assign lost   = 1'b0;
`endif

endmodule
